// File: rtl/branch_pkg.sv
// branch_pkg: shared branch funct3 codes and 2-bit predictor counter encodings
package branch_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;
endpackage

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch lookup, EX resolve and comparator signals of the predictor
interface branch_predict_unit_if #(parameter int PC_W = 32);
    logic [PC_W-1:0] if_pc_i;
    logic            pred_taken_o;
    logic [PC_W-1:0] pred_target_o;
    logic            ex_valid_i;
    logic            ex_stall_i;
    logic            ex_br_i;
    logic [2:0]      ex_funct3_i;
    logic [PC_W-1:0] ex_pc_i;
    logic [PC_W-1:0] ex_target_i;
    logic            ex_pred_taken_i;
    logic [PC_W-1:0] ex_pred_target_i;
    logic            br_less_i;
    logic            br_equal_i;
    logic            br_unsigned_o;
    logic            ex_taken_o;
    logic            mispredict_o;
    logic [PC_W-1:0] redirect_pc_o;
    modport master (
        output if_pc_i, ex_valid_i, ex_stall_i, ex_br_i, ex_funct3_i, ex_pc_i, ex_target_i,
               ex_pred_taken_i, ex_pred_target_i, br_less_i, br_equal_i,
        input  pred_taken_o, pred_target_o, br_unsigned_o, ex_taken_o, mispredict_o, redirect_pc_o
    );
    modport slave (
        input  if_pc_i, ex_valid_i, ex_stall_i, ex_br_i, ex_funct3_i, ex_pc_i, ex_target_i,
               ex_pred_taken_i, ex_pred_target_i, br_less_i, br_equal_i,
        output pred_taken_o, pred_target_o, br_unsigned_o, ex_taken_o, mispredict_o, redirect_pc_o
    );
endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// sat_counter2: 2-bit saturating taken/not-taken counter next-state
module sat_counter2
    import branch_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);
    // step toward taken or not-taken, holding at either end
    always_comb begin
        ctr_next = taken ? ((ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1))
                         : ((ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1));
    end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: flop BTB/BHT lookup at fetch, branch resolve and table update at EX
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    branch_predict_unit_if.slave  bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];
    ctr_t             ctr_q    [DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             if_hit;
    logic             ex_hit;
    logic             taken;
    logic             live;
    logic             upd;
    ctr_t             ctr_next;

    assign if_idx = bp.if_pc_i[IDX_W+1:2];
    assign ex_idx = bp.ex_pc_i[IDX_W+1:2];

    // fetch-side lookup; valid is cleared asynchronously so reset forces a miss at once
    always_comb begin
        if_hit           = valid_q[if_idx] && (tag_q[if_idx] == bp.if_pc_i[PC_W-1:IDX_W+2]);
        bp.pred_taken_o  = if_hit && (ctr_q[if_idx] >= CTR_WT);
        bp.pred_target_o = if_hit ? target_q[if_idx] : bp.if_pc_i + PC_W'(4);
    end

    // EX resolve: comparator result to taken, misprediction and redirect
    always_comb begin
        taken = (bp.ex_funct3_i == F3_BEQ) ? bp.br_equal_i
              : (bp.ex_funct3_i == F3_BNE) ? !bp.br_equal_i
              : (bp.ex_funct3_i == F3_BLT || bp.ex_funct3_i == F3_BLTU) ? bp.br_less_i
              : (bp.ex_funct3_i == F3_BGE || bp.ex_funct3_i == F3_BGEU) ? !bp.br_less_i
              : 1'b0;
        live             = bp.ex_valid_i && bp.ex_br_i;
        upd              = live && !bp.ex_stall_i;
        ex_hit           = valid_q[ex_idx] && (tag_q[ex_idx] == bp.ex_pc_i[PC_W-1:IDX_W+2]);
        bp.br_unsigned_o = bp.ex_funct3_i[1];
        bp.ex_taken_o    = live && taken;
        bp.mispredict_o  = live && ((taken != bp.ex_pred_taken_i) ||
                           (taken && bp.ex_pred_taken_i && (bp.ex_target_i != bp.ex_pred_target_i)));
        bp.redirect_pc_o = taken ? bp.ex_target_i : bp.ex_pc_i + PC_W'(4);
    end

    sat_counter2 u_ctr (
        .ctr      (ctr_q[ex_idx]),
        .taken    (taken),
        .ctr_next (ctr_next)
    );

    // valid bits: only resettable table state; set on a taken allocation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            valid_q <= '0;
        else if (upd && !ex_hit && taken)
            valid_q[ex_idx] <= 1'b1;
    end

    // entry payload: train counter on hit, allocate weakly-taken on taken miss
    always_ff @(posedge clk_i) begin
        if (upd && ex_hit) begin
            ctr_q[ex_idx] <= ctr_next;
            if (taken)
                target_q[ex_idx] <= bp.ex_target_i;
        end else if (upd && taken) begin
            tag_q[ex_idx]    <= bp.ex_pc_i[PC_W-1:IDX_W+2];
            target_q[ex_idx] <= bp.ex_target_i;
            ctr_q[ex_idx]    <= CTR_WT;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and randomized checks against a word-address predictor model
module tb_branch_predict_unit;
    import branch_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    branch_predict_unit_if #(.PC_W(32)) bp();
    branch_predict_unit #(.IDX_W(6), .PC_W(32)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bp(bp));

    int tests = 0;
    int fails = 0;

    // model: each slot remembers the full word address of the branch it holds
    bit          m_v    [64];
    logic [29:0] m_word [64];
    logic [31:0] m_tgt  [64];
    int          m_ctr  [64];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[slot(pc)] && (m_word[slot(pc)] == pc[31:2]);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_taken(input logic [2:0] f3, input bit less, input bit eq);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return less;
            3'd5, 3'd7: return !less;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit m_ex_taken();
        return bp.ex_valid_i && bp.ex_br_i && m_taken(bp.ex_funct3_i, bp.br_less_i, bp.br_equal_i);
    endfunction

    function automatic bit m_mp();
        bit tk = m_taken(bp.ex_funct3_i, bp.br_less_i, bp.br_equal_i);
        return bp.ex_valid_i && bp.ex_br_i && ((tk != bp.ex_pred_taken_i) ||
               (tk && bp.ex_pred_taken_i && bp.ex_target_i != bp.ex_pred_target_i));
    endfunction

    function automatic logic [31:0] m_redirect();
        return m_taken(bp.ex_funct3_i, bp.br_less_i, bp.br_equal_i) ? bp.ex_target_i : bp.ex_pc_i + 32'd4;
    endfunction

    task automatic commit();
        int s;
        bit tk;
        if (bp.ex_valid_i && bp.ex_br_i && !bp.ex_stall_i) begin
            s  = slot(bp.ex_pc_i);
            tk = m_taken(bp.ex_funct3_i, bp.br_less_i, bp.br_equal_i);
            if (m_hit(bp.ex_pc_i)) begin
                m_ctr[s] = tk ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1) : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
                if (tk) m_tgt[s] = bp.ex_target_i;
            end else if (tk) begin
                m_v[s] = 1'b1;
                m_word[s] = bp.ex_pc_i[31:2];
                m_tgt[s] = bp.ex_target_i;
                m_ctr[s] = 2;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        if (rst_ni) commit();
        @(negedge clk_i);
    endtask

    task automatic set_ex(input bit v, input bit st, input bit br, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt, input bit pt,
                          input logic [31:0] ptgt, input bit less, input bit eq);
        bp.ex_valid_i = v;
        bp.ex_stall_i = st;
        bp.ex_br_i = br;
        bp.ex_funct3_i = f3;
        bp.ex_pc_i = pc;
        bp.ex_target_i = tgt;
        bp.ex_pred_taken_i = pt;
        bp.ex_pred_target_i = ptgt;
        bp.br_less_i = less;
        bp.br_equal_i = eq;
    endtask

    task automatic idle();
        set_ex(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    task automatic test_reset();
        bp.if_pc_i = 32'h100;
        set_ex(0, 0, 1, F3_BEQ, 32'h100, 32'h80, 0, 32'h104, 0, 1);
        #1;
        tests++; if (bp.pred_taken_o !== 1'b0) begin fails++; $display("FAIL reset_pred_taken got %0b want 0", bp.pred_taken_o); end
        tests++; if (bp.pred_target_o !== 32'h104) begin fails++; $display("FAIL reset_pred_target got %h want 00000104", bp.pred_target_o); end
        tests++; if (bp.ex_taken_o !== 1'b0) begin fails++; $display("FAIL reset_ex_taken got %0b want 0", bp.ex_taken_o); end
        tests++; if (bp.mispredict_o !== 1'b0) begin fails++; $display("FAIL reset_mispredict got %0b want 0", bp.mispredict_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
        @(negedge clk_i);
    endtask

    task automatic test_beq();
        bp.if_pc_i = 32'h100;
        set_ex(1, 0, 1, F3_BEQ, 32'h100, 32'h80, 0, 32'h104, 0, 1);
        #1;
        tests++; if (bp.mispredict_o !== 1'b1) begin fails++; $display("FAIL beq_mispredict got %0b want 1", bp.mispredict_o); end
        tests++; if (bp.redirect_pc_o !== 32'h80) begin fails++; $display("FAIL beq_redirect got %h want 00000080", bp.redirect_pc_o); end
        tests++; if (bp.ex_taken_o !== 1'b1) begin fails++; $display("FAIL beq_ex_taken got %0b want 1", bp.ex_taken_o); end
        cycle();
        idle();
        #1;
        tests++; if (bp.pred_taken_o !== 1'b1) begin fails++; $display("FAIL beq_alloc_taken got %0b want 1", bp.pred_taken_o); end
        tests++; if (bp.pred_target_o !== 32'h80) begin fails++; $display("FAIL beq_alloc_target got %h want 00000080", bp.pred_target_o); end
    endtask

    task automatic test_bltu();
        bp.if_pc_i = 32'h100;
        set_ex(1, 0, 1, F3_BLTU, 32'h100, 32'h80, 1, 32'h80, 0, 0);
        #1;
        tests++; if (bp.br_unsigned_o !== 1'b1) begin fails++; $display("FAIL bltu_unsigned got %0b want 1", bp.br_unsigned_o); end
        tests++; if (bp.mispredict_o !== 1'b1) begin fails++; $display("FAIL bltu_mispredict got %0b want 1", bp.mispredict_o); end
        tests++; if (bp.redirect_pc_o !== 32'h104) begin fails++; $display("FAIL bltu_redirect got %h want 00000104", bp.redirect_pc_o); end
        cycle();
        idle();
        #1;
        tests++; if (bp.pred_taken_o !== 1'b0) begin fails++; $display("FAIL bltu_ctr_down got %0b want 0", bp.pred_taken_o); end
        bp.ex_funct3_i = F3_BLT;
        #1;
        tests++; if (bp.br_unsigned_o !== 1'b0) begin fails++; $display("FAIL blt_unsigned got %0b want 0", bp.br_unsigned_o); end
    endtask

    task automatic test_saturate();
        bp.if_pc_i = 32'h200;
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 0, 1, F3_BGE, 32'h200, 32'h300, m_pred(32'h200), m_ptgt(32'h200), 0, 0);
            #1;
            tests++; if (bp.ex_taken_o !== 1'b1) begin fails++; $display("FAIL sat_ex_taken[%0d] got %0b want 1", i, bp.ex_taken_o); end
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            set_ex(1, 0, 1, F3_BGE, 32'h200, 32'h300, 1, 32'h300, 1, 0);
            cycle();
            idle();
            #1;
            tests++; if (bp.pred_taken_o !== m_pred(32'h200)) begin fails++; $display("FAIL sat_down[%0d] got %0b want %0b", i, bp.pred_taken_o, m_pred(32'h200)); end
        end
    endtask

    task automatic test_stall();
        bp.if_pc_i = 32'h200;
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 1, 1, F3_BNE, 32'h200, 32'h300, 0, 32'h204, 0, 0);
            #1;
            tests++; if (bp.mispredict_o !== 1'b1) begin fails++; $display("FAIL stall_mispredict[%0d] got %0b want 1", i, bp.mispredict_o); end
            cycle();
            #1;
            tests++; if (bp.pred_taken_o !== 1'b0) begin fails++; $display("FAIL stall_no_write[%0d] got %0b want 0", i, bp.pred_taken_o); end
        end
        bp.ex_stall_i = 1'b0;
        cycle();
        idle();
        #1;
        tests++; if (bp.pred_taken_o !== m_pred(32'h200)) begin fails++; $display("FAIL stall_release got %0b want %0b", bp.pred_taken_o, m_pred(32'h200)); end
        set_ex(1, 0, 1, F3_BNE, 32'h200, 32'h300, 1, 32'h300, 0, 1);
        cycle();
        idle();
        #1;
        tests++; if (bp.pred_taken_o !== m_pred(32'h200)) begin fails++; $display("FAIL stall_single_step got %0b want %0b", bp.pred_taken_o, m_pred(32'h200)); end
    endtask

    task automatic test_same_cycle();
        bp.if_pc_i = 32'h200;
        set_ex(1, 0, 1, F3_BEQ, 32'h200, 32'h340, 0, 32'h204, 0, 1);
        #1;
        tests++; if (bp.pred_taken_o !== m_pred(32'h200)) begin fails++; $display("FAIL same_cycle_old got %0b want %0b", bp.pred_taken_o, m_pred(32'h200)); end
        cycle();
        idle();
        #1;
        tests++; if (bp.pred_taken_o !== m_pred(32'h200)) begin fails++; $display("FAIL same_cycle_after got %0b want %0b", bp.pred_taken_o, m_pred(32'h200)); end
        tests++; if (bp.pred_target_o !== m_ptgt(32'h200)) begin fails++; $display("FAIL same_cycle_target got %h want %h", bp.pred_target_o, m_ptgt(32'h200)); end
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    task automatic test_random();
        logic [31:0] pc;
        bit br;
        for (int i = 0; i < 400; i++) begin
            pc = rand_pc();
            br = ($urandom_range(0, 9) < 7);
            bp.if_pc_i = rand_pc();
            set_ex($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, br, 3'($urandom_range(0, 7)),
                   pc, $urandom_range(0, 1) ? rand_pc() : $urandom(),
                   br && ($urandom_range(0, 3) != 0 ? m_pred(pc) : 1'($urandom_range(0, 1))),
                   $urandom_range(0, 3) != 0 ? m_ptgt(pc) : rand_pc(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            tests++; if (bp.pred_taken_o !== m_pred(bp.if_pc_i)) begin fails++; $display("FAIL rnd_pred_taken[%0d] pc %h got %0b want %0b", i, bp.if_pc_i, bp.pred_taken_o, m_pred(bp.if_pc_i)); end
            tests++; if (bp.pred_target_o !== m_ptgt(bp.if_pc_i)) begin fails++; $display("FAIL rnd_pred_target[%0d] got %h want %h", i, bp.pred_target_o, m_ptgt(bp.if_pc_i)); end
            tests++; if (bp.br_unsigned_o !== (bp.ex_funct3_i == F3_BLTU || bp.ex_funct3_i == F3_BGEU || bp.ex_funct3_i == 3'b010 || bp.ex_funct3_i == 3'b011)) begin fails++; $display("FAIL rnd_unsigned[%0d] got %0b", i, bp.br_unsigned_o); end
            tests++; if (bp.ex_taken_o !== m_ex_taken()) begin fails++; $display("FAIL rnd_ex_taken[%0d] got %0b want %0b", i, bp.ex_taken_o, m_ex_taken()); end
            tests++; if (bp.mispredict_o !== m_mp()) begin fails++; $display("FAIL rnd_mispredict[%0d] got %0b want %0b", i, bp.mispredict_o, m_mp()); end
            if (m_mp()) begin
                tests++; if (bp.redirect_pc_o !== m_redirect()) begin fails++; $display("FAIL rnd_redirect[%0d] got %h want %h", i, bp.redirect_pc_o, m_redirect()); end
            end
            cycle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        bp.if_pc_i = 32'h400;
        set_ex(1, 0, 1, F3_BEQ, 32'h400, 32'h500, 0, 32'h404, 0, 1);
        cycle();
        set_ex(1, 0, 1, F3_BEQ, 32'h440, 32'h540, 0, 32'h444, 0, 1);
        #1;
        tests++; if (bp.pred_taken_o !== 1'b1) begin fails++; $display("FAIL rstmid_before got %0b want 1", bp.pred_taken_o); end
        #1;
        rst_ni = 1'b0;
        for (int s = 0; s < 64; s++) m_v[s] = 1'b0;
        #1;
        tests++; if (bp.pred_taken_o !== 1'b0) begin fails++; $display("FAIL rstmid_taken got %0b want 0", bp.pred_taken_o); end
        tests++; if (bp.pred_target_o !== 32'h404) begin fails++; $display("FAIL rstmid_target got %h want 00000404", bp.pred_target_o); end
        cycle();
        rst_ni = 1'b1;
        idle();
        bp.if_pc_i = 32'h440;
        #1;
        tests++; if (bp.pred_taken_o !== 1'b0) begin fails++; $display("FAIL rstmid_no_write got %0b want 0", bp.pred_taken_o); end
        tests++; if (bp.pred_target_o !== 32'h444) begin fails++; $display("FAIL rstmid_no_write_tgt got %h want 00000444", bp.pred_target_o); end
    endtask

    initial begin
        bp.if_pc_i = 32'h0;
        idle();
        for (int s = 0; s < 64; s++) m_v[s] = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_beq();
        test_bltu();
        test_saturate();
        test_stall();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic branch predictor and resolver for the 5-stage pipeline. Looks up a flop-based BTB/BHT on the IF-stage PC to predict taken/target. In EX it turns the branch comparator's `br_less`/`br_equal` into a final taken decision, flags mispredictions with the redirect PC, and updates the table. It also drives the comparator's `br_unsigned` select.

## Interface
- `IDX_W`, 6, index width; table depth = 2^IDX_W entries
- `PC_W`, 32, PC width; tag = `PC[PC_W-1:IDX_W+2]`

- `clk_i  in  1  clock, rising edge`
- `rst_ni  in  1  reset, asynchronous, active-low`
- `if_pc_i  in  PC_W  fetch PC`
- `pred_taken_o  out  1  prediction for if_pc_i (combinational)`
- `pred_target_o  out  PC_W  predicted target (combinational)`
- `ex_valid_i  in  1  EX holds a live instruction (not flushed or bubbled)`
- `ex_stall_i  in  1  EX frozen this cycle; suppresses update`
- `ex_br_i  in  1  EX instruction is a conditional branch`
- `ex_funct3_i  in  3  branch funct3`
- `ex_pc_i  in  PC_W  branch PC`
- `ex_target_i  in  PC_W  computed branch target`
- `ex_pred_taken_i  in  1  prediction carried down from IF`
- `ex_pred_target_i  in  PC_W  predicted target carried down from IF`
- `br_less_i  in  1  comparator less result`
- `br_equal_i  in  1  comparator equal result`
- `br_unsigned_o  out  1  comparator unsigned select = ex_funct3_i[1]`
- `ex_taken_o  out  1  resolved branch outcome`
- `mispredict_o  out  1  flush IF/ID and redirect, valid in EX cycle`
- `redirect_pc_o  out  PC_W  correct next PC when mispredict_o=1`

## Operation
- Entry fields: `valid`, `tag`, `target[PC_W-1:0]`, `ctr[1:0]`. Index = `PC[IDX_W+1:2]`.
- Lookup: hit = valid & tag match.
  - `pred_taken_o = hit & ctr[1]`.
  - `pred_target_o = target` when hit, else `if_pc_i+4`.
- Resolve (`ex_br_i`): taken is decided by funct3:
  - 000 (BEQ): `eq`
  - 001 (BNE): `~eq`
  - 100 (BLT), 110 (BLTU): `less`
  - 101 (BGE), 111 (BGEU): `~less`
  - 010 and 011: not taken
- `ex_taken_o = ex_valid_i & ex_br_i & taken`.
- `mispredict_o = ex_valid_i & ex_br_i & ((taken != ex_pred_taken_i) | (taken & ex_pred_taken_i & ex_target_i != ex_pred_target_i))`.
- `redirect_pc_o = taken ? ex_target_i : ex_pc_i+4`. Output is don't-care when `mispredict_o=0`, but must still be driven (no X).
- Update enable = `ex_valid_i & ex_br_i & ~ex_stall_i`. On update:
  - Hit: counter saturates (00 strongly not-taken … 11 strongly taken); +1 if taken, −1 if not. Target rewritten when taken.
  - Miss and taken: allocate — `valid=1`, tag, target, `ctr=10`.
  - Miss and not taken: no write.
- Non-branch instructions (`ex_br_i=0`) with `ex_pred_taken_i=1` (aliasing) are not handled here. The decode stage guarantees `ex_pred_taken_i` is cleared for non-branches.
- PC arithmetic is modulo 2^PC_W; `+4` wraps.

## Timing
- Lookup and resolve outputs are combinational, with zero latency.
- Table writes take effect at the rising edge after the update cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. There is no write-through bypass.
- `ex_stall_i=1` with a live branch: outputs still reflect the current EX inputs, but no write happens. The write occurs in the cycle the stall drops, so each branch updates exactly once.
- Reset (asserted any time, including mid-update): all `valid` bits clear immediately, and `pred_taken_o=0`, `pred_target_o=if_pc_i+4` while reset is held. `tag`, `target` and `ctr` are not reset. There is no in-flight write on reset release.
- Reset value of every resolve output is a function of inputs only. With `ex_valid_i=0`: `ex_taken_o=0`, `mispredict_o=0`.

## Structure
- Shared package `branch_pkg` holds:
  - funct3 constants `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`
  - counter encodings `CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11
- One sub-module, `sat_counter2`: 2-bit saturating next-state function (`ctr`, `taken` → `ctr_next`), instantiated once on the update path.
- Table arrays are flops (no SRAM), with `valid` as a separate resettable vector.

## Test plan
- Reset, then lookup `if_pc_i=0x100` → `pred_taken_o=0`, `pred_target_o=0x104`.
- BEQ at `ex_pc_i=0x100`, target `0x80`, `br_equal_i=1`, `ex_pred_taken_i=0` → `mispredict_o=1`, `redirect_pc_o=0x80`. Next cycle lookup `0x100` → taken, `0x80`, ctr=10.
- BLTU (`funct3`=110) → `br_unsigned_o=1`. With `br_less_i=0` and predicted taken → `mispredict_o=1`, `redirect_pc_o=ex_pc_i+4`. Counter goes 10→01 and the next lookup predicts not-taken.
- Four taken updates on one entry → ctr saturates at 11. One not-taken → 10, still predicts taken.
- Update with `ex_stall_i=1` for 3 cycles, then released → exactly one counter step.
- Same-index lookup and update in one cycle → old prediction returned. Assert `rst_ni=0` mid-sequence → `pred_taken_o=0` immediately.
